// File: rtl/wvb_reader.sv
// Waveform buffer readout: pops a header, streams 3 header words plus n samples
// over a valid/ready interface, using a credit-limited skid FIFO behind the storage latency.
module wvb_reader #(
   parameter int P_DATA_WIDTH = 28,
   parameter int P_ADR_WIDTH  = 15,
   parameter int P_HDR_WIDTH  = 87,
   parameter int P_LTC_WIDTH  = 48,
   parameter int P_RD_LATENCY = 2
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    en_i,
   input  logic                    hdr_empty_i,
   input  logic [P_HDR_WIDTH-1:0]  hdr_data_i,
   output logic                    hdr_rdreq_o,
   input  logic [P_DATA_WIDTH-1:0] wvb_data_i,
   output logic                    wvb_rdreq_o,
   output logic                    wvb_rddone_o,
   output logic [31:0]             dout_tdata_o,
   output logic                    dout_tvalid_o,
   input  logic                    dout_tready_i,
   output logic                    dout_tlast_o,
   output logic                    busy_o,
   output logic [15:0]             evt_cnt_o
);

   localparam int DEPTH    = P_RD_LATENCY + 2;
   localparam int PW       = $clog2(DEPTH);
   localparam int CW       = 4;
   localparam int MISC_LSB = 2 * P_ADR_WIDTH + P_LTC_WIDTH;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_HDR0 = 3'd1;
   localparam logic [2:0] S_HDR1 = 3'd2;
   localparam logic [2:0] S_HDR2 = 3'd3;
   localparam logic [2:0] S_DATA = 3'd4;
   localparam logic [2:0] S_DONE = 3'd5;

   logic [2:0]               state_q, state_d;
   logic [P_LTC_WIDTH-1:0]   ltc_q;
   logic [8:0]               misc_q;
   logic [15:0]              n_q, rd_issued_q, rd_recv_q, evt_cnt_q;
   logic [P_RD_LATENCY-1:0]  pipe_q;
   logic [P_DATA_WIDTH-1:0]  mem_q [DEPTH];
   logic [PW-1:0]            wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]            cnt_q, in_flight;
   logic [P_ADR_WIDTH-1:0]   start_in, stop_in, span;
   logic [15:0]              n_in;
   logic                     push, pop, last_word, credit_ok, rd_phase;
   logic [31:0]              sample_word;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign stop_in  = hdr_data_i[P_ADR_WIDTH-1:0];
   assign start_in = hdr_data_i[2*P_ADR_WIDTH-1:P_ADR_WIDTH];
   assign span     = stop_in - start_in;
   assign n_in     = 16'(span) + 16'd1;

   // Combinational pop is gated by rst_n so no header is consumed while held in reset.
   assign hdr_rdreq_o = rst_n && (state_q == S_IDLE) && en_i && !hdr_empty_i;

   always_comb begin
      in_flight = '0;
      for (int i = 0; i < P_RD_LATENCY; i++) in_flight = in_flight + CW'(pipe_q[i]);
   end

   // Reserve FIFO space for every read still in the storage pipeline.
   assign credit_ok   = (cnt_q + in_flight) < DEPTH_C;
   assign rd_phase    = (state_q == S_HDR0) || (state_q == S_HDR1) ||
                        (state_q == S_HDR2) || (state_q == S_DATA);
   assign wvb_rdreq_o = rd_phase && (rd_issued_q < n_q) && credit_ok;
   assign push        = pipe_q[P_RD_LATENCY-1];
   assign pop         = (state_q == S_DATA) && (cnt_q != '0) && dout_tready_i;
   assign last_word   = (rd_recv_q == 16'(n_q - 16'd1));

   always_comb begin
      sample_word = '0;
      sample_word[P_DATA_WIDTH-1:0] = mem_q[rd_ptr_q];
   end

   always_comb begin
      dout_tdata_o  = '0;
      dout_tvalid_o = 1'b0;
      dout_tlast_o  = 1'b0;
      case (state_q)
         S_HDR0: begin
            dout_tvalid_o = 1'b1;
            dout_tdata_o  = {8'hA5, 8'h00, n_q};
         end
         S_HDR1: begin
            dout_tvalid_o = 1'b1;
            dout_tdata_o  = ltc_q[47:16];
         end
         S_HDR2: begin
            dout_tvalid_o = 1'b1;
            dout_tdata_o  = {ltc_q[15:0], 7'b0, misc_q};
         end
         S_DATA: begin
            dout_tvalid_o = (cnt_q != '0);
            dout_tdata_o  = (cnt_q != '0) ? sample_word : 32'd0;
            dout_tlast_o  = (cnt_q != '0) && last_word;
         end
         default: ;
      endcase
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (hdr_rdreq_o) state_d = S_HDR0;
         S_HDR0:  if (dout_tready_i) state_d = S_HDR1;
         S_HDR1:  if (dout_tready_i) state_d = S_HDR2;
         S_HDR2:  if (dout_tready_i) state_d = S_DATA;
         S_DATA:  if (pop && last_word) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         ltc_q       <= '0;
         misc_q      <= '0;
         n_q         <= '0;
         rd_issued_q <= '0;
         rd_recv_q   <= '0;
         evt_cnt_q   <= '0;
         pipe_q      <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         cnt_q       <= '0;
      end else begin
         state_q   <= state_d;
         pipe_q[0] <= wvb_rdreq_o;
         for (int i = 1; i < P_RD_LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
         if (hdr_rdreq_o) begin
            ltc_q       <= hdr_data_i[MISC_LSB-1:2*P_ADR_WIDTH];
            misc_q      <= hdr_data_i[P_HDR_WIDTH-1:MISC_LSB];
            n_q         <= n_in;
            rd_issued_q <= '0;
            rd_recv_q   <= '0;
         end else begin
            if (wvb_rdreq_o) rd_issued_q <= rd_issued_q + 16'd1;
            if (pop)         rd_recv_q   <= rd_recv_q + 16'd1;
         end
         if (state_q == S_DONE) evt_cnt_q <= evt_cnt_q + 16'd1;
         if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
         if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
         if (push && !pop)      cnt_q <= cnt_q + 1'b1;
         else if (pop && !push) cnt_q <= cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= wvb_data_i;
   end

   assign wvb_rddone_o = (state_q == S_DONE);
   assign busy_o       = (state_q != S_IDLE);
   assign evt_cnt_o    = evt_cnt_q;

endmodule

// File: tb/tb_wvb_reader.sv
// Randomized bench for wvb_reader: models buffer storage, header FIFO and the
// expected word stream from the header/sample rules, and scores every transfer.
module tb_wvb_reader;
   localparam int L = 2;

   logic        clk = 1'b0;
   logic        rst_n, en, hdr_empty, hdr_rdreq, wvb_rdreq, wvb_rddone;
   logic [86:0] hdr_data;
   logic [27:0] wvb_data;
   logic [31:0] tdata;
   logic        tvalid, tready, tlast, busy;
   logic [15:0] evt_cnt;

   always #5 clk = ~clk;

   wvb_reader #(.P_RD_LATENCY(L)) dut (
      .clk(clk), .rst_n(rst_n), .en_i(en), .hdr_empty_i(hdr_empty),
      .hdr_data_i(hdr_data), .hdr_rdreq_o(hdr_rdreq), .wvb_data_i(wvb_data),
      .wvb_rdreq_o(wvb_rdreq), .wvb_rddone_o(wvb_rddone), .dout_tdata_o(tdata),
      .dout_tvalid_o(tvalid), .dout_tready_i(tready), .dout_tlast_o(tlast),
      .busy_o(busy), .evt_cnt_o(evt_cnt)
   );

   logic [27:0] mem [32768];
   logic [27:0] dl [L];
   logic [86:0] hdr_q [$];
   logic [32:0] exp_q [$];
   logic [32:0] log_q [$];
   logic [32:0] prev_word;
   logic [14:0] rd_addr;
   int          checks = 0, errors = 0;
   int          cyc = 0, mdl_evt = 0, rd_evt = 0, cur_n = 0, last_done_cyc = 0;
   bit          have_done = 0, gap_chk = 0, prev_stall = 0, evt_chk_pend = 0, rnd_ready = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic logic [86:0] mk_hdr(input int start, input int stop,
                                          input logic [47:0] ltc, input logic [8:0] misc);
      return {misc, ltc, 15'(start), 15'(stop)};
   endfunction

   // Reference: expected words for a popped header, straight from the stream format.
   task automatic expect_event(input logic [86:0] h);
      int          start, stop, n;
      logic [47:0] ltc;
      logic [8:0]  misc;
      stop  = int'(h[14:0]);
      start = int'(h[29:15]);
      ltc   = h[77:30];
      misc  = h[86:78];
      n     = ((stop - start + 32768) % 32768) + 1;
      exp_q.push_back({1'b0, 32'hA500_0000 | 32'(n)});
      exp_q.push_back({1'b0, ltc[47:16]});
      exp_q.push_back({1'b0, ltc[15:0], 7'b0, misc});
      for (int i = 0; i < n; i++)
         exp_q.push_back({(i == n - 1), 4'h0, mem[(start + i) % 32768]});
      cur_n = n;
   endtask

   task automatic tick();
      bit hq, rq;
      @(negedge clk);
      cyc++;
      hq = hdr_rdreq;
      rq = wvb_rdreq;
      if (evt_chk_pend) begin
         check("evt_cnt", evt_cnt, mdl_evt);
         evt_chk_pend = 0;
      end
      if (prev_stall) check("hold", {tvalid, tlast, tdata}, {1'b1, prev_word});
      prev_stall = tvalid && !tready;
      prev_word  = {tlast, tdata};
      if (tvalid && tready) begin
         log_q.push_back({tlast, tdata});
         check("exp_avail", exp_q.size() > 0, 1);
         if (exp_q.size() > 0) check("word", {tlast, tdata}, exp_q.pop_front());
      end
      if (rq) rd_evt++;
      if (hq) begin
         check("busy_idle", busy, 0);
         if (gap_chk && have_done) check("idle_gap", cyc - last_done_cyc, 1);
         check("hdr_avail", hdr_q.size() > 0, 1);
         if (hdr_q.size() > 0) begin
            expect_event(hdr_q[0]);
            rd_addr = hdr_q[0][29:15];
            hdr_q.delete(0);
         end
         rd_evt = 0;
      end
      if (wvb_rddone) begin
         check("evt_drained", exp_q.size(), 0);
         check("rd_count", rd_evt, cur_n);
         mdl_evt       = (mdl_evt + 1) & 16'hFFFF;
         evt_chk_pend  = 1;
         have_done     = 1;
         last_done_cyc = cyc;
      end
      @(posedge clk);
      #1;
      if (!rst_n) begin
         exp_q.delete();
         prev_stall   = 0;
         evt_chk_pend = 0;
         mdl_evt      = 0;
      end
      for (int k = L - 1; k > 0; k--) dl[k] = dl[k-1];
      dl[0] = (rq && rst_n) ? mem[rd_addr] : 28'($urandom);
      if (rq) rd_addr = rd_addr + 15'd1;
      wvb_data  = dl[L-1];
      hdr_empty = (hdr_q.size() == 0);
      hdr_data  = (hdr_q.size() > 0) ? hdr_q[0] : 87'({$urandom, $urandom, $urandom});
      tready    = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
   endtask

   task automatic wait_evt(input int target, input int budget);
      for (int i = 0; i < budget && mdl_evt != target; i++) tick();
      check("evt_wait", mdl_evt, target);
      tick();
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_tvalid"}, tvalid, 0);
      check({tag, "_tdata"}, tdata, 0);
      check({tag, "_tlast"}, tlast, 0);
      check({tag, "_hdr_rdreq"}, hdr_rdreq, 0);
      check({tag, "_wvb_rdreq"}, wvb_rdreq, 0);
      check({tag, "_rddone"}, wvb_rddone, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_evt_cnt"}, evt_cnt, 0);
   endtask

   initial begin
      int s, n;
      rst_n = 1'b0; en = 1'b0; tready = 1'b1; hdr_empty = 1'b1;
      hdr_data = '0; wvb_data = '0; rd_addr = '0;
      for (int i = 0; i < 32768; i++) mem[i] = 28'($urandom);
      for (int k = 0; k < L; k++) dl[k] = '0;

      // Header pending and en high while in reset: nothing may be popped.
      hdr_q.push_back(mk_hdr(10, 13, 48'h1234_5678_9ABC, 9'h1FF));
      en = 1'b1;
      repeat (3) tick();
      check_reset_outputs("por");
      check("por_hdr_kept", hdr_q.size(), 1);
      rst_n = 1'b1;

      wait_evt(1, 200);
      check("t1_len", log_q.size(), 7);
      check("t1_w0", log_q[0], {1'b0, 32'hA500_0004});
      check("t1_w1", log_q[1], {1'b0, 32'h1234_5678});
      check("t1_w2", log_q[2], {1'b0, 32'h9ABC_01FF});
      check("t1_last", log_q[6][32], 1);
      check("t1_evt", evt_cnt, 1);

      log_q.delete();
      hdr_q.push_back(mk_hdr(32765, 2, {$urandom, 16'($urandom)}, 9'($urandom)));
      wait_evt(2, 200);
      check("t2_len", log_q.size(), 9);
      check("t2_w0", log_q[0], {1'b0, 32'hA500_0006});

      log_q.delete();
      hdr_q.push_back(mk_hdr(500, 500, {$urandom, 16'($urandom)}, 9'($urandom)));
      wait_evt(3, 200);
      check("t3_len", log_q.size(), 4);
      check("t3_w0", log_q[0], {1'b0, 32'hA500_0001});
      check("t3_last", log_q[3][32], 1);

      log_q.delete();
      rnd_ready = 1;
      s = $urandom_range(0, 32767);
      hdr_q.push_back(mk_hdr(s, (s + 99) % 32768, {$urandom, 16'($urandom)}, 9'($urandom)));
      wait_evt(4, 2000);
      check("t4_len", log_q.size(), 103);
      rnd_ready = 0;

      gap_chk = 1; have_done = 0;
      hdr_q.push_back(mk_hdr(100, 104, {$urandom, 16'($urandom)}, 9'($urandom)));
      hdr_q.push_back(mk_hdr(32760, 0, {$urandom, 16'($urandom)}, 9'($urandom)));
      wait_evt(6, 500);
      gap_chk = 0;
      check("t5_evt", evt_cnt, 6);

      // Reset in the middle of the sample phase.
      log_q.delete();
      hdr_q.push_back(mk_hdr(2000, 2049, {$urandom, 16'($urandom)}, 9'($urandom)));
      for (int i = 0; i < 300 && log_q.size() < 8; i++) tick();
      check("t6_in_data", log_q.size() >= 8, 1);
      rst_n = 1'b0;
      #1;
      check_reset_outputs("mid");
      repeat (2) tick();
      rst_n = 1'b1;
      hdr_q.push_back(mk_hdr(7000, 7006, {$urandom, 16'($urandom)}, 9'($urandom)));
      wait_evt(1, 200);
      check("t6_evt", evt_cnt, 1);

      rnd_ready = 1;
      for (int e = 0; e < 6; e++) begin
         s = $urandom_range(0, 32767);
         n = $urandom_range(1, 40);
         hdr_q.push_back(mk_hdr(s, (s + n - 1) % 32768, {$urandom, 16'($urandom)}, 9'($urandom)));
         wait_evt(mdl_evt + 1, 1000);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
